// File: rtl/fpu_cmp_pkg.sv
// Shared types and helpers for the FP compare pipe.
// Modes, class/compare bundles, binary32 classify, final result mux.
package fpu_cmp_pkg;

   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;
   localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;

   localparam logic [31:0] FP_TRUE = 32'h3f800000;

   typedef enum logic [1:0] {
      CMP_FEQ  = 2'b00,
      CMP_FLT  = 2'b01,
      CMP_FLE  = 2'b10,
      CMP_RSVD = 2'b11
   } cmp_mode_e;

   typedef struct packed {
      logic is_nan;
      logic is_snan;
      logic is_zero;
      logic sign;
   } fp_class_t;

   // Classification plus raw compare results, ahead of the final mux.
   typedef struct packed {
      cmp_mode_e mode;
      logic      any_nan;
      logic      any_snan;
      logic      both_zero;
      logic      bit_eq;
      logic      s1;
      logic      s2;
      logic      mag_lt;
      logic      mag_gt;
   } cmp_pre_t;

   typedef struct packed {
      logic res;
      logic inv;
   } cmp_res_t;

   function automatic fp_class_t fp_class(input logic [FP_W-1:0] x);
      fp_class_t c;
      logic [FP_EXP_W-1:0] e;
      logic [FP_MAN_W-1:0] m;
      e = x[FP_W-2:FP_MAN_W];
      m = x[FP_MAN_W-1:0];
      c.is_nan  = (&e) & (|m);
      c.is_snan = c.is_nan & ~m[FP_MAN_W-1];
      c.is_zero = ~(|e) & ~(|m);
      c.sign    = x[FP_W-1];
      return c;
   endfunction

   function automatic cmp_res_t cmp_resolve(input cmp_pre_t p);
      cmp_res_t r;
      logic lt;
      r = '0;
      // Ordered less-than; sign decides unless both signs agree.
      if (p.both_zero)
         lt = 1'b0;
      else if (p.s1 != p.s2)
         lt = p.s1;
      else if (!p.s1)
         lt = p.mag_lt;
      else
         lt = p.mag_gt;
      unique case (p.mode)
         CMP_FEQ: begin
            r.res = ~p.any_nan & (p.bit_eq | p.both_zero);
            r.inv = p.any_snan;
         end
         CMP_FLT: begin
            r.res = ~p.any_nan & lt;
            r.inv = p.any_nan;
         end
         CMP_FLE: begin
            r.res = ~p.any_nan & (lt | p.both_zero | p.bit_eq);
            r.inv = p.any_nan;
         end
         default: begin
            r.res = 1'b0;
            r.inv = 1'b1;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/fcmp_core.sv
// Combinational classify + compare for FEQ/FLT/FLE.
// Ports: mode, x1, x2 in; pre (pre-mux bundle), res {res, inv} out.
module fcmp_core
   import fpu_cmp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   localparam int W    = 1 + EXP_W + MAN_W
) (
   input  logic [1:0]   mode,
   input  logic [W-1:0] x1,
   input  logic [W-1:0] x2,
   output cmp_pre_t     pre,
   output cmp_res_t     res
);

   function automatic fp_class_t classify(input logic [W-1:0] x);
      fp_class_t c;
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] m;
      e = x[W-2:MAN_W];
      m = x[MAN_W-1:0];
      c.is_nan  = (&e) & (|m);
      c.is_snan = c.is_nan & ~m[MAN_W-1];
      c.is_zero = ~(|e) & ~(|m);
      c.sign    = x[W-1];
      return c;
   endfunction

   fp_class_t c1;
   fp_class_t c2;

   always_comb begin
      c1            = classify(x1);
      c2            = classify(x2);
      pre           = '0;
      pre.mode      = cmp_mode_e'(mode);
      pre.any_nan   = c1.is_nan | c2.is_nan;
      pre.any_snan  = c1.is_snan | c2.is_snan;
      pre.both_zero = c1.is_zero & c2.is_zero;
      pre.bit_eq    = (x1 == x2);
      pre.s1        = c1.sign;
      pre.s2        = c2.sign;
      pre.mag_lt    = x1[W-2:0] < x2[W-2:0];
      pre.mag_gt    = x1[W-2:0] > x2[W-2:0];
      res           = cmp_resolve(pre);
   end

endmodule

// File: rtl/fcmp_pipe.sv
// Pipelined FP compare with tag sideband and output back-pressure.
// Ports: sys_clk, rstn, in_valid/in_ready, mode, x1, x2, tag_in -> y, invalid, tag_out, out_valid/out_ready.
module fcmp_pipe
   import fpu_cmp_pkg::*;
#(
   parameter int          EXP_W    = 8,
   parameter int          MAN_W    = 23,
   parameter int          LATENCY  = 1,
   parameter int          TAG_W    = 5,
   parameter logic [31:0] TRUE_VAL = FP_TRUE,
   localparam int         W        = 1 + EXP_W + MAN_W
) (
   input  logic             sys_clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mode,
   input  logic [W-1:0]     x1,
   input  logic [W-1:0]     x2,
   input  logic [TAG_W-1:0] tag_in,
   output logic [31:0]      y,
   output logic             invalid,
   output logic [TAG_W-1:0] tag_out,
   output logic             out_valid,
   input  logic             out_ready
);

   // With two or more stages the final mux moves after stage 1.
   localparam bit SPLIT = (LATENCY >= 2);

   cmp_pre_t core_pre;
   cmp_res_t core_res;
   cmp_res_t rsv;
   logic     advance;

   logic [LATENCY-1:0] vld_q, vld_d;
   logic [LATENCY-1:0] res_q, res_d;
   logic [LATENCY-1:0] inv_q, inv_d;
   logic [TAG_W-1:0]   tag_q [LATENCY];
   logic [TAG_W-1:0]   tag_d [LATENCY];
   cmp_pre_t           pre_q, pre_d;

   fcmp_core #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_core (
      .mode (mode),
      .x1   (x1),
      .x2   (x2),
      .pre  (core_pre),
      .res  (core_res)
   );

   assign advance = ~vld_q[LATENCY-1] | out_ready;
   assign in_ready = advance;

   // Stage-1 classification feeds the mux for stage 2.
   assign rsv = cmp_resolve(pre_q);

   always_comb begin
      vld_d = vld_q;
      res_d = res_q;
      inv_d = inv_q;
      tag_d = tag_q;
      pre_d = pre_q;
      if (advance) begin
         vld_d[0] = in_valid;
         res_d[0] = core_res.res;
         inv_d[0] = core_res.inv;
         tag_d[0] = tag_in;
         pre_d    = core_pre;
         for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
            if (SPLIT && i == 1) begin
               res_d[i] = rsv.res;
               inv_d[i] = rsv.inv;
            end else begin
               res_d[i] = res_q[i-1];
               inv_d[i] = inv_q[i-1];
            end
         end
      end
   end

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         vld_q <= '0;
         res_q <= '0;
         inv_q <= '0;
         pre_q <= '0;
         for (int i = 0; i < LATENCY; i++)
            tag_q[i] <= '0;
      end else begin
         vld_q <= vld_d;
         res_q <= res_d;
         inv_q <= inv_d;
         pre_q <= pre_d;
         for (int i = 0; i < LATENCY; i++)
            tag_q[i] <= tag_d[i];
      end
   end

   assign out_valid = vld_q[LATENCY-1];
   assign y         = res_q[LATENCY-1] ? TRUE_VAL : 32'h0;
   assign invalid   = inv_q[LATENCY-1];
   assign tag_out   = tag_q[LATENCY-1];

endmodule

// File: tb/tb_fcmp_pipe.sv
// Self-checking bench for fcmp_pipe at LATENCY=3.
// Directed compare table, streaming, stall and mid-stream reset.
module tb_fcmp_pipe;

   localparam int LAT = 3;
   localparam logic [31:0] ONE = 32'h3f800000;
   localparam logic [31:0] TWO = 32'h40000000;

   logic        sys_clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  mode;
   logic [31:0] x1, x2;
   logic [4:0]  tag_in;
   logic [31:0] y;
   logic        invalid;
   logic [4:0]  tag_out;
   logic        out_valid;
   logic        out_ready;

   int errs = 0;
   int nchk = 0;

   always #5 sys_clk = ~sys_clk;

   fcmp_pipe #(
      .LATENCY (LAT)
   ) dut (
      .sys_clk   (sys_clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .x1        (x1),
      .x2        (x2),
      .tag_in    (tag_in),
      .y         (y),
      .invalid   (invalid),
      .tag_out   (tag_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] a;
      logic [31:0] b;
      logic        res;
      logic        inv;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string nm, input longint act, input longint exp);
      nchk++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic stream(input int n, input int base,
                         input int stall_len, input bit chk_lat);
      int sent, rcvd, a_cyc, b_cyc, extra;
      logic [31:0] py;
      logic [4:0]  ptag, etag;
      bit pstall;
      sent = 0; rcvd = 0; a_cyc = 0; b_cyc = 0;
      pstall = 0; py = '0; ptag = '0;
      for (int cyc = 0; cyc < 200 && rcvd < n; cyc++) begin
         @(posedge sys_clk); #1;
         out_ready = (cyc >= stall_len);
         if (sent < n) begin
            in_valid = 1'b1;
            mode     = 2'b00;
            tag_in   = 5'(base + sent);
            x1       = ONE;
            x2       = tag_in[0] ? TWO : ONE;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge sys_clk);
         if (in_valid && in_ready) begin
            if (sent == 0) a_cyc = cyc;
            sent++;
         end
         if (out_valid && !out_ready) begin
            check("stall_in_ready", in_ready, 0);
            if (pstall) begin
               check("stall_y_hold", y, py);
               check("stall_tag_hold", tag_out, ptag);
            end
            pstall = 1; py = y; ptag = tag_out;
         end else begin
            pstall = 0;
         end
         if (out_valid && out_ready) begin
            etag = 5'(base + rcvd);
            if (rcvd == 0) begin
               b_cyc = cyc;
               if (chk_lat) check("latency", cyc - a_cyc, LAT);
            end else if (stall_len == 0) begin
               check("back_to_back", cyc - b_cyc, rcvd);
            end
            check("stream_tag", tag_out, etag);
            check("stream_y", y, etag[0] ? 32'h0 : ONE);
            rcvd++;
         end
      end
      check("beats_received", rcvd, n);
      in_valid = 1'b0;
      out_ready = 1'b1;
      extra = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge sys_clk);
         if (out_valid) extra++;
      end
      check("no_extra_beats", extra, 0);
   endtask

   initial begin
      vecs[0]  = '{2'd0, 32'h3f800000, 32'h3f800000, 1'b1, 1'b0};
      vecs[1]  = '{2'd0, 32'h00000000, 32'h80000000, 1'b1, 1'b0};
      vecs[2]  = '{2'd0, 32'h7fc00000, 32'h7fc00000, 1'b0, 1'b0};
      vecs[3]  = '{2'd0, 32'h7f800001, 32'h3f800000, 1'b0, 1'b1};
      vecs[4]  = '{2'd1, 32'hbf800000, 32'h40000000, 1'b1, 1'b0};
      vecs[5]  = '{2'd1, 32'hc0000000, 32'hbf800000, 1'b1, 1'b0};
      vecs[6]  = '{2'd1, 32'hbf800000, 32'hc0000000, 1'b0, 1'b0};
      vecs[7]  = '{2'd1, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
      vecs[8]  = '{2'd2, 32'h00000000, 32'h80000000, 1'b1, 1'b0};
      vecs[9]  = '{2'd1, 32'h7fc00000, 32'h3f800000, 1'b0, 1'b1};
      vecs[10] = '{2'd2, 32'h3f800000, 32'h3f800000, 1'b1, 1'b0};
      vecs[11] = '{2'd1, 32'h3f800000, 32'h40000000, 1'b1, 1'b0};
      vecs[12] = '{2'd1, 32'h40000000, 32'h3f800000, 1'b0, 1'b0};
      vecs[13] = '{2'd3, 32'h3f800000, 32'h3f800000, 1'b0, 1'b1};
      vecs[14] = '{2'd2, 32'h40000000, 32'h3f800000, 1'b0, 1'b0};
      vecs[15] = '{2'd0, 32'h7f800000, 32'h7f800000, 1'b1, 1'b0};
      vecs[16] = '{2'd2, 32'h7f800001, 32'h00000000, 1'b0, 1'b1};

      rstn = 1'b0;
      in_valid = 1'b0;
      mode = 2'b00;
      x1 = '0;
      x2 = '0;
      tag_in = '0;
      out_ready = 1'b1;
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_y", y, 0);
      check("rst_invalid", invalid, 0);
      check("rst_tag_out", tag_out, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge sys_clk);
      @(negedge sys_clk);
      rstn = 1'b1;

      foreach (vecs[i]) begin
         int w;
         @(posedge sys_clk); #1;
         in_valid = 1'b1;
         mode = vecs[i].mode;
         x1 = vecs[i].a;
         x2 = vecs[i].b;
         tag_in = 5'(i);
         @(posedge sys_clk); #1;
         in_valid = 1'b0;
         w = 0;
         while (!out_valid && w < 20) begin
            @(negedge sys_clk);
            w++;
         end
         check("vec_arrived", out_valid, 1);
         check($sformatf("vec%0d_y", i), y, vecs[i].res ? ONE : 32'h0);
         check($sformatf("vec%0d_inv", i), invalid, vecs[i].inv);
         check($sformatf("vec%0d_tag", i), tag_out, i);
         @(posedge sys_clk);
      end

      // Back-to-back stream of tags 0..7.
      stream(8, 0, 0, 1'b1);

      // Fill the pipe with out_ready low, stall five full cycles.
      stream(6, 8, 8, 1'b0);

      // Reset with beats in flight.
      begin
         int seen;
         out_ready = 1'b1;
         for (int k = 0; k < 3; k++) begin
            @(posedge sys_clk); #1;
            in_valid = 1'b1;
            mode = 2'b00;
            x1 = ONE;
            x2 = ONE;
            tag_in = 5'(20 + k);
         end
         @(posedge sys_clk); #1;
         in_valid = 1'b0;
         #2;
         check("pre_rst_out_valid", out_valid, 1);
         rstn = 1'b0;
         #1;
         check("async_rst_out_valid", out_valid, 0);
         check("async_rst_y", y, 0);
         check("async_rst_tag", tag_out, 0);
         @(posedge sys_clk);
         @(posedge sys_clk); #2;
         rstn = 1'b1;
         seen = 0;
         for (int k = 0; k < 8; k++) begin
            @(negedge sys_clk);
            if (out_valid) seen++;
         end
         check("no_stale_after_rst", seen, 0);
         stream(1, 30, 0, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

endmodule
